window_scheduler: RTL and testbench
===================================

// Module: window_scheduler
// PURPOSE
//  Frame-level controller for the cascade classifier pipeline. On a start handshake it scans
//  every window position over the image in raster order and issues each (x,y) origin to the
//  data fetcher. It keeps the origins of in-flight windows in an internal FIFO, matches each
//  in-order classifier result to its origin, and emits positive detections and an end-of-frame beat.
// PARAMETERS
//  IMG_WIDTH        45  image width, pixels
//  IMG_HEIGHT       45  image height, pixels
//  FEATURE_WIDTH    25  window width, pixels (<= IMG_WIDTH)
//  FEATURE_HEIGHT   25  window height, pixels (<= IMG_HEIGHT)
//  STEP              1  window stride in x and y, >= 1
//  MAX_OUTSTANDING   4  origin FIFO depth = max windows issued but not yet resolved, >= 1
//  (local) NX=(IMG_WIDTH-FEATURE_WIDTH)/STEP+1, NY likewise, NUM_WIN=NX*NY
//  (local) W_X=$clog2(IMG_WIDTH), W_Y=$clog2(IMG_HEIGHT), W_CNT=$clog2(NUM_WIN+1)
// PORTS
//  clk           in   1      clock
//  rst           in   1      asynchronous reset, active-high
//  start_valid   in   1      frame start request
//  start_ready   out  1      1 only in IDLE
//  win_valid     out  1      window origin to data fetcher
//  win_ready     in   1      fetcher accepts origin
//  win_x         out  W_X    window origin column
//  win_y         out  W_Y    window origin row
//  result_valid  in   1      classifier verdict for oldest in-flight window
//  result_ready  out  1      verdict accepted
//  result_data   in   1      1 = face detected
//  det_valid     out  1      detection / end-of-frame beat
//  det_ready     in   1      downstream accepts beat
//  det_x         out  W_X    detected window column (0 on eot beat)
//  det_y         out  W_Y    detected window row (0 on eot beat)
//  det_eot       out  1      1 = end-of-frame beat
//  det_count     out  W_CNT  number of detections in frame; valid on eot beat
//  busy          out  1      1 in any state but IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; all valids 0, busy 0, start_ready 1; coords, count, FIFO cleared.
//  - Any handshake completes on valid&ready at rising clk. Outputs are registered; valid stays
//    high and data stable until accepted.
//  - FSM: IDLE -(start hs)-> RUN -(last window issued)-> DRAIN -(FIFO empty & det slot free)->
//    EOT -(det hs with det_eot=1)-> IDLE. start_ready=0 outside IDLE; start ignored there.
//  - RUN: win_valid=1 whenever FIFO not full. On win hs push (win_x,win_y) to FIFO, then
//    x+=STEP; past last column x=0,y+=STEP; past last row -> DRAIN. First origin (0,0),
//    last ((NX-1)*STEP,(NY-1)*STEP). win_valid first asserts the cycle after start hs.
//  - result_ready = FIFO not empty & (result_data==0 | det slot free); it may depend on
//    result_data combinationally. Verdicts are strictly in issue order. On result hs pop FIFO head;
//    if result_data=1 load det slot with head coords, det_eot=0, and increment det_count.
//  - Simultaneous win hs and result hs: push and pop same cycle, occupancy unchanged; a
//    full FIFO may accept a push only after that cycle's pop is registered (no bypass).
//  - Never more than MAX_OUTSTANDING windows unresolved; FIFO never overflows/underflows.
//  - EOT beat: det_valid=1, det_eot=1, det_x=det_y=0, det_count=final count; count
//    cleared on entry to IDLE.
//  - det_count saturates never (max NUM_WIN fits W_CNT).
//  - Reset mid-frame: abort immediately, all state to reset values, no eot beat emitted.
//  - Latency: start hs -> first win_valid 1 cycle; result hs -> det_valid 1 cycle.
// TESTING
//  1 defaults, win_ready=1, all results 0 -> 441 origins (0,0),(1,0)..(20,0),(0,1)..(20,20); one eot beat, count=0.
//  2 defaults, result 1 for windows #0 and #440 -> det (0,0), det (20,20), eot count=2, then IDLE.
//  3 result_valid held 0 -> exactly 4 win hs then win_valid=0; first verdict -> 5th origin issued.
//  4 hit with det_ready=0 for 10 cycles -> result_ready=0 for next hit, no loss or reorder.
//  5 rst pulse after 100 win hs -> all outputs at reset values; new start restarts at (0,0).
//  6 STEP=4 -> origins x,y in {0,4,..,20}: 36 windows; start during RUN ignored, start_ready=0.

Source files
------------

// File: rtl/window_scheduler.sv
// Frame scanner for the cascade classifier: issues window origins in raster order,
// remembers in-flight origins and reports detections followed by an end-of-frame beat.
module window_scheduler #(
    parameter int IMG_WIDTH       = 45,
    parameter int IMG_HEIGHT      = 45,
    parameter int FEATURE_WIDTH   = 25,
    parameter int FEATURE_HEIGHT  = 25,
    parameter int STEP            = 1,
    parameter int MAX_OUTSTANDING = 4,
    localparam int NX      = (IMG_WIDTH - FEATURE_WIDTH) / STEP + 1,
    localparam int NY      = (IMG_HEIGHT - FEATURE_HEIGHT) / STEP + 1,
    localparam int NUM_WIN = NX * NY,
    localparam int W_X     = $clog2(IMG_WIDTH),
    localparam int W_Y     = $clog2(IMG_HEIGHT),
    localparam int W_CNT   = $clog2(NUM_WIN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    output logic             win_valid,
    input  logic             win_ready,
    output logic [W_X-1:0]   win_x,
    output logic [W_Y-1:0]   win_y,
    input  logic             result_valid,
    output logic             result_ready,
    input  logic             result_data,
    output logic             det_valid,
    input  logic             det_ready,
    output logic [W_X-1:0]   det_x,
    output logic [W_Y-1:0]   det_y,
    output logic             det_eot,
    output logic [W_CNT-1:0] det_count,
    output logic             busy
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int OCC_W = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [W_X-1:0]   LAST_X   = W_X'((NX - 1) * STEP);
    localparam logic [W_Y-1:0]   LAST_Y   = W_Y'((NY - 1) * STEP);
    localparam logic [W_X-1:0]   STEP_X   = W_X'(STEP);
    localparam logic [W_Y-1:0]   STEP_Y   = W_Y'(STEP);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, EOT} state_t;

    state_t           state_reg, state_next;
    logic [W_X-1:0]   x_reg;
    logic [W_Y-1:0]   y_reg;
    logic             start_ready_reg;
    logic             busy_reg;
    logic             win_valid_reg, win_valid_next;
    logic             det_valid_reg;
    logic             det_eot_reg;
    logic [W_X-1:0]   det_x_reg;
    logic [W_Y-1:0]   det_y_reg;
    logic [W_CNT-1:0] det_count_reg;

    // Origin FIFO: small register array, head read combinationally so a verdict
    // can load the detection slot in the same cycle it is accepted.
    logic [W_X-1:0]   fifo_x [MAX_OUTSTANDING];
    logic [W_Y-1:0]   fifo_y [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [OCC_W-1:0] occ_reg, occ_next;
    logic [W_X-1:0]   head_x;
    logic [W_Y-1:0]   head_y;

    logic start_hs, win_hs, res_hs, det_hs;
    logic fifo_empty, det_free, hit, last_win, eot_load;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        start_hs     = start_valid & start_ready_reg;
        win_hs       = win_valid_reg & win_ready;
        det_hs       = det_valid_reg & det_ready;
        fifo_empty   = (occ_reg == '0);
        det_free     = ~det_valid_reg | det_ready;
        // A hit needs the detection slot; a miss can always retire.
        result_ready = ~fifo_empty & (~result_data | det_free);
        res_hs       = result_valid & result_ready;
        hit          = res_hs & result_data;
        last_win     = (x_reg == LAST_X) && (y_reg == LAST_Y);
        head_x       = fifo_x[rd_ptr_reg];
        head_y       = fifo_y[rd_ptr_reg];
        eot_load     = (state_reg == DRAIN) && fifo_empty && det_free;
        occ_next     = occ_reg + OCC_W'(win_hs) - OCC_W'(res_hs);

        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_hs) state_next = RUN;
            RUN:     if (win_hs && last_win) state_next = DRAIN;
            DRAIN:   if (eot_load) state_next = EOT;
            EOT:     if (det_hs) state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Occupancy comes from registers only, so a slot freed by a pop is
        // offered to the fetcher one cycle later.
        win_valid_next = (state_next == RUN) && (occ_next != FULL_OCC);
    end

    always_ff @(posedge clk) begin
        if (win_hs) begin
            fifo_x[wr_ptr_reg] <= x_reg;
            fifo_y[wr_ptr_reg] <= y_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            start_ready_reg <= 1'b1;
            busy_reg        <= 1'b0;
            win_valid_reg   <= 1'b0;
            x_reg           <= '0;
            y_reg           <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            occ_reg         <= '0;
            det_valid_reg   <= 1'b0;
            det_eot_reg     <= 1'b0;
            det_x_reg       <= '0;
            det_y_reg       <= '0;
            det_count_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            start_ready_reg <= (state_next == IDLE);
            busy_reg        <= (state_next != IDLE);
            win_valid_reg   <= win_valid_next;
            occ_reg         <= occ_next;

            if (win_hs) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (res_hs) rd_ptr_reg <= ptr_inc(rd_ptr_reg);

            if (start_hs) begin
                x_reg <= '0;
                y_reg <= '0;
            end else if (win_hs) begin
                if (x_reg == LAST_X) begin
                    x_reg <= '0;
                    y_reg <= last_win ? '0 : y_reg + STEP_Y;
                end else begin
                    x_reg <= x_reg + STEP_X;
                end
            end

            // hit and eot_load are exclusive: one needs a non-empty FIFO, the other an empty one.
            if (hit) begin
                det_valid_reg <= 1'b1;
                det_eot_reg   <= 1'b0;
                det_x_reg     <= head_x;
                det_y_reg     <= head_y;
                det_count_reg <= det_count_reg + 1'b1;
            end else if (eot_load) begin
                det_valid_reg <= 1'b1;
                det_eot_reg   <= 1'b1;
                det_x_reg     <= '0;
                det_y_reg     <= '0;
            end else if (det_hs) begin
                det_valid_reg <= 1'b0;
                det_eot_reg   <= 1'b0;
                if (state_reg == EOT) det_count_reg <= '0;
            end
        end
    end

    assign start_ready = start_ready_reg;
    assign busy        = busy_reg;
    assign win_valid   = win_valid_reg;
    assign win_x       = x_reg;
    assign win_y       = y_reg;
    assign det_valid   = det_valid_reg;
    assign det_eot     = det_eot_reg;
    assign det_x       = det_x_reg;
    assign det_y       = det_y_reg;
    assign det_count   = det_count_reg;

endmodule

// File: tb/tb_window_scheduler.sv
// Directed bench for window_scheduler: a scan/queue model checks every cycle, and
// literal expectations per scenario pin the model to hand-computed values.
`timescale 1ns/1ps
module tb_window_scheduler;

    localparam int NX   = 21;
    localparam int NUM  = 441;
    localparam int MAXO = 4;
    localparam int NX4  = 6;
    localparam int NUM4 = 36;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // default-parameter instance
    logic       start_valid = 1'b0, win_ready = 1'b1, result_valid = 1'b0;
    logic       result_data = 1'b0, det_ready = 1'b1;
    logic       start_ready, win_valid, result_ready, det_valid, det_eot, busy;
    logic [5:0] win_x, win_y, det_x, det_y;
    logic [8:0] det_count;

    // STEP=4 instance
    logic       s4_start_valid = 1'b0, s4_win_ready = 1'b1, s4_result_valid = 1'b1;
    logic       s4_result_data = 1'b0, s4_det_ready = 1'b1;
    logic       s4_start_ready, s4_win_valid, s4_result_ready, s4_det_valid, s4_det_eot, s4_busy;
    logic [5:0] s4_win_x, s4_win_y, s4_det_x, s4_det_y;
    logic [5:0] s4_det_count;

    window_scheduler dut (
        .clk(clk), .rst(rst),
        .start_valid(start_valid), .start_ready(start_ready),
        .win_valid(win_valid), .win_ready(win_ready), .win_x(win_x), .win_y(win_y),
        .result_valid(result_valid), .result_ready(result_ready), .result_data(result_data),
        .det_valid(det_valid), .det_ready(det_ready), .det_x(det_x), .det_y(det_y),
        .det_eot(det_eot), .det_count(det_count), .busy(busy)
    );

    window_scheduler #(.STEP(4)) dut4 (
        .clk(clk), .rst(rst),
        .start_valid(s4_start_valid), .start_ready(s4_start_ready),
        .win_valid(s4_win_valid), .win_ready(s4_win_ready), .win_x(s4_win_x), .win_y(s4_win_y),
        .result_valid(s4_result_valid), .result_ready(s4_result_ready), .result_data(s4_result_data),
        .det_valid(s4_det_valid), .det_ready(s4_det_ready), .det_x(s4_det_x), .det_y(s4_det_y),
        .det_eot(s4_det_eot), .det_count(s4_det_count), .busy(s4_busy)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d @%0t", nm, act, exp, $time);
        end
    endtask

    // model of the default instance: frame progress plus queues of in-flight and pending detections
    bit running = 1'b0;
    int issued = 0, resolved = 0, hits = 0, eot_seen = 0, last_eot_count = -1;
    int qx[$], qy[$], dqx[$], dqy[$];
    int wlog_x[$], wlog_y[$], dlog_x[$], dlog_y[$];
    bit hit_mask [NUM];
    int resp_budget = -1;
    bit win_rand = 1'b0, det_rand = 1'b0;
    logic det_hold = 1'b1;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_win_valid", win_valid, 0);
            chk("rst_start_ready", start_ready, 1);
            chk("rst_busy", busy, 0);
            chk("rst_det_valid", det_valid, 0);
            chk("rst_det_eot", det_eot, 0);
            chk("rst_det_count", det_count, 0);
            chk("rst_result_ready", result_ready, 0);
            chk("rst_win_x", win_x, 0);
            chk("rst_win_y", win_y, 0);
            running = 1'b0;
            qx.delete(); qy.delete(); dqx.delete(); dqy.delete();
        end else begin
            chk("start_ready", start_ready, !running);
            chk("busy", busy, running);
            chk("win_valid", win_valid, running && (issued < NUM) && (qx.size() < MAXO));
            if (win_valid) begin
                chk("win_x", win_x, issued % NX);
                chk("win_y", win_y, issued / NX);
            end
            if (qx.size() == 0)
                chk("rr_empty", result_ready, 0);
            else if (!result_data || !det_valid)
                chk("rr_free", result_ready, 1);
            else if (!det_ready)
                chk("rr_blocked", result_ready, 0);
            if (det_valid) begin
                if (dqx.size() > 0) begin
                    chk("det_eot", det_eot, 0);
                    chk("det_x", det_x, dqx[0]);
                    chk("det_y", det_y, dqy[0]);
                end else begin
                    chk("eot_flag", det_eot, 1);
                    chk("eot_x", det_x, 0);
                    chk("eot_y", det_y, 0);
                    chk("eot_count", det_count, hits);
                    chk("eot_issued", issued, NUM);
                    chk("eot_inflight", qx.size(), 0);
                end
            end else begin
                chk("det_pending", dqx.size(), 0);
            end

            if (start_valid && start_ready) begin
                running = 1'b1;
                issued = 0; resolved = 0; hits = 0;
                qx.delete(); qy.delete(); dqx.delete(); dqy.delete();
                wlog_x.delete(); wlog_y.delete(); dlog_x.delete(); dlog_y.delete();
                $display("[%0t] start", $time);
            end
            if (win_valid && win_ready) begin
                qx.push_back(issued % NX);
                qy.push_back(issued / NX);
                wlog_x.push_back(int'(win_x));
                wlog_y.push_back(int'(win_y));
                $display("[%0t] win #%0d (%0d,%0d)", $time, issued, win_x, win_y);
                issued++;
            end
            if (result_valid && result_ready) begin
                if (qx.size() > 0) begin
                    if (result_data) begin
                        dqx.push_back(qx[0]);
                        dqy.push_back(qy[0]);
                        hits++;
                    end
                    void'(qx.pop_front());
                    void'(qy.pop_front());
                end
                resolved++;
                if (resp_budget > 0) resp_budget--;
            end
            if (det_valid && det_ready) begin
                if (!det_eot) begin
                    dlog_x.push_back(int'(det_x));
                    dlog_y.push_back(int'(det_y));
                    if (dqx.size() > 0) begin
                        void'(dqx.pop_front());
                        void'(dqy.pop_front());
                    end
                    $display("[%0t] det (%0d,%0d)", $time, det_x, det_y);
                end else begin
                    eot_seen++;
                    last_eot_count = int'(det_count);
                    running = 1'b0;
                    $display("[%0t] eot count=%0d", $time, det_count);
                end
            end
        end
    end

    // STEP=4 instance: all verdicts are misses, so only origins and the eot beat matter
    bit s4_running = 1'b0;
    int s4_issued = 0, s4_eot_seen = 0, s4_last_x = -1, s4_last_y = -1;

    always @(negedge clk) begin
        if (!rst) begin
            chk("s4_start_ready", s4_start_ready, !s4_running);
            chk("s4_busy", s4_busy, s4_running);
            if (s4_win_valid) begin
                chk("s4_win_x", s4_win_x, (s4_issued % NX4) * 4);
                chk("s4_win_y", s4_win_y, (s4_issued / NX4) * 4);
            end
            if (s4_start_valid && s4_start_ready) begin
                s4_running = 1'b1;
                s4_issued = 0;
                $display("[%0t] s4 start", $time);
            end
            if (s4_win_valid && s4_win_ready) begin
                s4_last_x = int'(s4_win_x);
                s4_last_y = int'(s4_win_y);
                $display("[%0t] s4 win #%0d (%0d,%0d)", $time, s4_issued, s4_win_x, s4_win_y);
                s4_issued++;
            end
            if (s4_det_valid && s4_det_ready) begin
                chk("s4_det_eot", s4_det_eot, 1);
                chk("s4_det_count", s4_det_count, 0);
                s4_eot_seen++;
                s4_running = 1'b0;
                $display("[%0t] s4 eot count=%0d", $time, s4_det_count);
            end
        end
    end

    // classifier / downstream responder for the default instance
    initial begin
        forever begin
            @(posedge clk);
            #1;
            result_valid = 1'b0;
            result_data  = 1'b0;
            if (!rst && resp_budget != 0 && qx.size() > 0) begin
                result_valid = 1'b1;
                if (resolved < NUM) result_data = hit_mask[resolved];
            end
            win_ready = win_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            det_ready = det_rand ? 1'($urandom_range(0, 1)) : det_hold;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
    endtask

    task automatic wait_eot(input int target, input int budget, input string nm);
        int c = 0;
        while (eot_seen < target && c < budget) begin
            @(posedge clk);
            c++;
        end
        #1;
        chk(nm, eot_seen, target);
    endtask

    task automatic clear_mask();
        foreach (hit_mask[i]) hit_mask[i] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int saved;
        clear_mask();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        cycles(2);

        // 1: all misses
        start_frame();
        wait_eot(1, 3000, "t1_eot");
        chk("t1_windows", wlog_x.size(), 441);
        if (wlog_x.size() == 441) begin
            chk("t1_o0_x", wlog_x[0], 0);
            chk("t1_o20_x", wlog_x[20], 20);
            chk("t1_o21_x", wlog_x[21], 0);
            chk("t1_o21_y", wlog_y[21], 1);
            chk("t1_last_x", wlog_x[440], 20);
            chk("t1_last_y", wlog_y[440], 20);
        end
        chk("t1_count", last_eot_count, 0);
        chk("t1_dets", dlog_x.size(), 0);
        cycles(2);
        chk("t1_idle", busy, 0);

        // 2: hits on first and last window, with fetcher and downstream backpressure
        hit_mask[0] = 1'b1;
        hit_mask[440] = 1'b1;
        win_rand = 1'b1;
        det_rand = 1'b1;
        start_frame();
        wait_eot(2, 6000, "t2_eot");
        chk("t2_dets", dlog_x.size(), 2);
        if (dlog_x.size() == 2) begin
            chk("t2_d0_x", dlog_x[0], 0);
            chk("t2_d0_y", dlog_y[0], 0);
            chk("t2_d1_x", dlog_x[1], 20);
            chk("t2_d1_y", dlog_y[1], 20);
        end
        chk("t2_count", last_eot_count, 2);
        win_rand = 1'b0;
        det_rand = 1'b0;
        clear_mask();
        cycles(3);
        chk("t2_idle_start_ready", start_ready, 1);
        chk("t2_idle_busy", busy, 0);

        // 3: verdicts withheld
        resp_budget = 0;
        start_frame();
        cycles(20);
        chk("t3_issued", wlog_x.size(), 4);
        chk("t3_win_valid_low", win_valid, 0);
        resp_budget = 1;
        cycles(8);
        chk("t3_fifth", wlog_x.size(), 5);
        if (wlog_x.size() == 5) begin
            chk("t3_fifth_x", wlog_x[4], 4);
            chk("t3_fifth_y", wlog_y[4], 0);
        end
        resp_budget = -1;
        wait_eot(3, 3000, "t3_eot");

        // 4: consecutive hits while downstream stalls
        hit_mask[2] = 1'b1;
        hit_mask[3] = 1'b1;
        det_hold = 1'b0;
        cycles(2);
        start_frame();
        c = 0;
        while (!det_valid && c < 100) begin
            @(posedge clk);
            c++;
        end
        #1;
        chk("t4_det_seen", det_valid, 1);
        cycles(8);
        chk("t4_rr_blocked", result_ready, 0);
        chk("t4_rd_hit", result_data, 1);
        chk("t4_det_x", det_x, 2);
        chk("t4_issued", wlog_x.size(), 7);
        cycles(2);
        det_hold = 1'b1;
        wait_eot(4, 3000, "t4_eot");
        chk("t4_dets", dlog_x.size(), 2);
        if (dlog_x.size() == 2) begin
            chk("t4_d0_x", dlog_x[0], 2);
            chk("t4_d1_x", dlog_x[1], 3);
            chk("t4_d1_y", dlog_y[1], 0);
        end
        chk("t4_count", last_eot_count, 2);
        clear_mask();
        cycles(2);

        // 5: reset mid-frame
        start_frame();
        c = 0;
        while (wlog_x.size() < 100 && c < 1000) begin
            @(posedge clk);
            c++;
        end
        #1;
        chk("t5_reached_100", wlog_x.size(), 100);
        saved = eot_seen;
        rst = 1'b1;
        cycles(2);
        chk("t5_rst_win_valid", win_valid, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_start_ready", start_ready, 1);
        chk("t5_rst_det_valid", det_valid, 0);
        chk("t5_rst_result_ready", result_ready, 0);
        rst = 1'b0;
        cycles(5);
        chk("t5_no_eot", eot_seen, saved);
        chk("t5_idle", busy, 0);
        start_frame();
        cycles(3);
        chk("t5_restarted", wlog_x.size() > 0, 1);
        if (wlog_x.size() > 0) begin
            chk("t5_restart_x", wlog_x[0], 0);
            chk("t5_restart_y", wlog_y[0], 0);
        end
        wait_eot(saved + 1, 3000, "t5_eot");
        chk("t5_windows", wlog_x.size(), 441);
        chk("t5_count", last_eot_count, 0);

        // 6: STEP=4 instance, start requests during RUN are ignored
        s4_start_valid = 1'b1;
        @(posedge clk);
        #1;
        s4_start_valid = 1'b0;
        cycles(5);
        s4_start_valid = 1'b1;
        cycles(3);
        chk("t6_start_ready_low", s4_start_ready, 0);
        chk("t6_busy", s4_busy, 1);
        cycles(3);
        s4_start_valid = 1'b0;
        c = 0;
        while (s4_eot_seen < 1 && c < 500) begin
            @(posedge clk);
            c++;
        end
        #1;
        chk("t6_eot", s4_eot_seen, 1);
        chk("t6_windows", s4_issued, 36);
        chk("t6_last_x", s4_last_x, 20);
        chk("t6_last_y", s4_last_y, 20);
        cycles(5);
        chk("t6_single_eot", s4_eot_seen, 1);
        chk("t6_idle", s4_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
